trace_capture_buffer: RTL and testbench

Parametrised on-chip trace buffer for SLC-3 debug. It generalises the bench-only internal-signal monitor (PC, IR, R1, nzp, BEN) into a synthesisable block. CH probe channels of WIDTH bits each are captured into a DEPTH-entry circular buffer around a programmable trigger, and the capture is read back word-by-word after completion. It sits beside the datapath in the top level, with its read port driven from switches/HEX or a host.

---
 rtl/trace_capture_buffer.sv | 87 ++++++++
 tb/tb_trace_capture_buffer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/trace_capture_buffer.sv
// trace_capture_buffer: multi-channel circular trace buffer captured around a programmable trigger.
module trace_capture_buffer #(
  parameter int WIDTH = 16,
  parameter int CH = 4,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [CH*WIDTH-1:0]   probe_i,
  input  logic                  sample_en_i,
  input  logic                  arm_i,
  input  logic [CW-1:0]         trig_ch_i,
  input  logic [WIDTH-1:0]      trig_val_i,
  input  logic [AW:0]           post_count_i,
  input  logic [AW-1:0]         rd_addr_i,
  input  logic [CW-1:0]         rd_ch_i,
  output logic [WIDTH-1:0]      rd_data_o,
  output logic [1:0]            state_o,
  output logic [AW:0]           fill_o,
  output logic [AW-1:0]         trig_pos_o
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARMED = 2'b01, POST = 2'b10, DONE = 2'b11} state_e;
  state_e                state_q;
  logic [AW-1:0]         wr_ptr_q, trig_phys_q, post_q, post_left_q, oldest, rd_phys;
  logic [AW:0]           fill_q;
  logic [WIDTH-1:0]      rd_data_q, trig_sel, rd_sel;
  logic                  trig_ok, hit, we;
  logic [CH*WIDTH-1:0]   mem_q [DEPTH];
  // channel selects only match in-range indices, so trig_ch >= CH never triggers
  always_comb begin
    trig_ok = 1'b0;
    trig_sel = '0;
    rd_sel = '0;
    for (int c = 0; c < CH; c++) begin
      if (trig_ch_i == CW'(c)) begin
        trig_ok = 1'b1;
        trig_sel = probe_i[c*WIDTH +: WIDTH];
      end
      if (rd_ch_i == CW'(c)) rd_sel = mem_q[rd_phys][c*WIDTH +: WIDTH];
    end
  end
  assign hit = sample_en_i && trig_ok && trig_sel == trig_val_i;
  assign we = sample_en_i && !arm_i && (state_q == ARMED || state_q == POST);
  assign oldest = fill_q[AW] ? wr_ptr_q : '0;
  assign rd_phys = oldest + rd_addr_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      fill_q <= '0;
      trig_phys_q <= '0;
      post_q <= '0;
      post_left_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_sel;
      if (arm_i) begin
        state_q <= ARMED;
        wr_ptr_q <= '0;
        fill_q <= '0;
        post_q <= post_count_i[AW] ? AW'(DEPTH - 1) : post_count_i[AW-1:0];
      end else if (we) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        fill_q <= fill_q[AW] ? fill_q : fill_q + 1'b1;
        if (state_q == ARMED && hit) begin
          trig_phys_q <= wr_ptr_q;
          post_left_q <= post_q;
          state_q <= (post_q == '0) ? DONE : POST;
        end
        if (state_q == POST) begin
          post_left_q <= post_left_q - 1'b1;
          if (post_left_q == AW'(1)) state_q <= DONE;
        end
      end
    end
  end
  // storage is not reset; a read colliding with a write sees the old word
  always_ff @(posedge clk_i) begin
    if (we) mem_q[wr_ptr_q] <= probe_i;
  end
  assign rd_data_o = rd_data_q;
  assign state_o = state_q;
  assign fill_o = fill_q;
  assign trig_pos_o = trig_phys_q - oldest;
endmodule

// File: tb/tb_trace_capture_buffer.sv
// tb_trace_capture_buffer: directed checks of trace_capture_buffer (4-channel main DUT, 3-channel DUT for out-of-range trigger).
module tb_trace_capture_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [63:0] probe = '0;
  logic sample_en = 1'b0, arm = 1'b0;
  logic [1:0] trig_ch = '0, rd_ch = '0;
  logic [15:0] trig_val = '0;
  logic [4:0] post_count = '0;
  logic [3:0] rd_addr = '0;
  logic [15:0] rd_data, rd_data3;
  logic [1:0] state, state3;
  logic [4:0] fill, fill3;
  logic [3:0] trig_pos, trig_pos3;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  trace_capture_buffer u_dut (
    .clk_i(clk), .rst_i(rst), .probe_i(probe), .sample_en_i(sample_en), .arm_i(arm),
    .trig_ch_i(trig_ch), .trig_val_i(trig_val), .post_count_i(post_count),
    .rd_addr_i(rd_addr), .rd_ch_i(rd_ch), .rd_data_o(rd_data), .state_o(state),
    .fill_o(fill), .trig_pos_o(trig_pos)
  );
  trace_capture_buffer #(.CH(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .probe_i(probe[47:0]), .sample_en_i(sample_en), .arm_i(arm),
    .trig_ch_i(trig_ch), .trig_val_i(trig_val), .post_count_i(post_count),
    .rd_addr_i(rd_addr), .rd_ch_i(rd_ch), .rd_data_o(rd_data3), .state_o(state3),
    .fill_o(fill3), .trig_pos_o(trig_pos3)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] pv(input int v);
    return {16'(v + 'h3000), 16'(v + 'h2000), 16'(v + 'h1000), 16'(v)};
  endfunction
  task automatic sample(input int v, input logic en);
    probe = pv(v);
    sample_en = en;
    tick;
    sample_en = 1'b0;
  endtask
  task automatic do_arm(input logic [4:0] pc, input logic [1:0] tc, input logic [15:0] tv);
    post_count = pc;
    trig_ch = tc;
    trig_val = tv;
    arm = 1'b1;
    tick;
    arm = 1'b0;
  endtask
  task automatic rd(input int a, input int c, input logic [15:0] exp, input string tag);
    rd_addr = 4'(a);
    rd_ch = 2'(c);
    tick;
    check(tag, rd_data, exp);
  endtask
  initial begin
    #12;
    check("rst_state", state, 2'b00);
    check("rst_fill", fill, 0);
    check("rst_rd", rd_data, 0);
    check("rst_tpos", trig_pos, 0);
    check("rst_state3", state3, 2'b00);
    rst = 1'b0;
    tick;
    // basic capture around trigger value 5, three post samples
    do_arm(5'd3, 2'd0, 16'h0005);
    check("arm_state", state, 2'b01);
    check("arm_fill", fill, 0);
    for (int i = 0; i <= 8; i++) begin
      sample(i, 1'b1);
      if (i == 4) check("pre_trig_state", state, 2'b01);
      if (i == 5) check("post_state", state, 2'b10);
      if (i == 7) check("post7_state", state, 2'b10);
    end
    check("done_state", state, 2'b11);
    check("done_fill", fill, 9);
    check("done_tpos", trig_pos, 5);
    sample(9, 1'b1);
    sample(10, 1'b1);
    check("frozen_fill", fill, 9);
    check("frozen_state", state, 2'b11);
    for (int a = 0; a <= 8; a++) rd(a, 0, 16'(a), $sformatf("basic_rd%0d", a));
    rd(2, 1, 16'h1002, "basic_rd_ch1");
    // async reset during POST with fill 7
    do_arm(5'd3, 2'd0, 16'h0005);
    for (int i = 0; i <= 6; i++) sample(i, 1'b1);
    check("mid_state", state, 2'b10);
    check("mid_fill", fill, 7);
    rd(1, 0, 16'h0001, "mid_rd");
    #2 rst = 1'b1;
    #1;
    check("async_state", state, 2'b00);
    check("async_fill", fill, 0);
    check("async_rd", rd_data, 0);
    rst = 1'b0;
    tick;
    do_arm(5'd3, 2'd0, 16'h0005);
    check("rearm_state", state, 2'b01);
    // wrap: trigger at 30, four post samples
    do_arm(5'd4, 2'd0, 16'd30);
    for (int i = 0; i <= 34; i++) begin
      sample(i, 1'b1);
      if (i == 33) check("wrap_pre_done", state, 2'b10);
    end
    check("wrap_state", state, 2'b11);
    check("wrap_fill", fill, 16);
    check("wrap_tpos", trig_pos, 11);
    rd(0, 0, 16'd19, "wrap_rd0");
    rd(15, 0, 16'd34, "wrap_rd15");
    rd(0, 1, 16'h1013, "wrap_rd0_ch1");
    // post_count 0: done on trigger edge
    do_arm(5'd0, 2'd0, 16'd3);
    for (int i = 0; i <= 3; i++) sample(i, 1'b1);
    check("p0_state", state, 2'b11);
    check("p0_fill", fill, 4);
    check("p0_tpos", trig_pos, 3);
    // post_count 20 clamps to 15
    do_arm(5'd20, 2'd0, 16'd0);
    for (int i = 0; i <= 15; i++) begin
      sample(i, 1'b1);
      if (i == 14) check("p20_pre_done", state, 2'b10);
    end
    check("p20_state", state, 2'b11);
    check("p20_fill", fill, 16);
    check("p20_tpos", trig_pos, 0);
    // Sample_en gaps, trigger on channel 3
    do_arm(5'd2, 2'd3, 16'h3003);
    for (int i = 0; i <= 5; i++) sample(i, (i % 2) == 0);
    check("gap_ignored_state", state, 2'b01);
    check("gap_ignored_fill", fill, 3);
    trig_val = 16'h3006;
    for (int i = 6; i <= 10; i++) sample(i, (i % 2) == 0);
    check("gap_state", state, 2'b11);
    check("gap_fill", fill, 6);
    check("gap_tpos", trig_pos, 3);
    rd(3, 3, 16'h3006, "gap_rd3_ch3");
    rd(1, 2, 16'h2002, "gap_rd1_ch2");
    rd(5, 1, 16'h100A, "gap_rd5_ch1");
    rd(4, 0, 16'h0008, "gap_rd4_ch0");
    // Arm in POST coincident with a write discards the sample
    do_arm(5'd5, 2'd0, 16'd2);
    for (int i = 0; i <= 2; i++) sample(i, 1'b1);
    check("rearm_post_state", state, 2'b10);
    probe = pv(3);
    sample_en = 1'b1;
    arm = 1'b1;
    tick;
    arm = 1'b0;
    sample_en = 1'b0;
    check("arm_in_post_state", state, 2'b01);
    check("arm_in_post_fill", fill, 0);
    sample(7, 1'b1);
    rd(0, 0, 16'd7, "arm_in_post_rd0");
    // out-of-range trigger channel on the 3-channel instance
    do_arm(5'd0, 2'd3, 16'h3001);
    for (int i = 0; i < 10; i++) sample(i, 1'b1);
    check("oor_mid_fill", fill3, 10);
    for (int i = 10; i < 20; i++) sample(i, 1'b1);
    check("oor_state", state3, 2'b01);
    check("oor_fill", fill3, 16);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
